// File: rtl/output_argmax.sv
// Tracks the signed maximum output-layer node and its index across one inference, publishing it on ready's rising edge.
// Node updates and completion land on the accepting clock edge; results hold until the next start.
module output_argmax #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CLASSES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_inference,
    input  logic                  ready,
    input  logic                  output_layer,
    input  logic                  node_valid,
    input  logic [DATA_WIDTH-1:0] node_value,
    input  logic [7:0]            node_index,
    output logic [7:0]            class_id,
    output logic [DATA_WIDTH-1:0] class_value,
    output logic [7:0]            node_count,
    output logic                  result_valid,
    output logic                  done_pulse,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state_q;
    logic                  ready_q;
    logic                  have_max_q;
    logic [7:0]            class_id_q;
    logic [DATA_WIDTH-1:0] class_value_q;
    logic [7:0]            node_count_q;
    logic                  result_valid_q;
    logic                  done_pulse_q;
    logic                  error_q;

    logic                  accept;
    logic                  in_range;
    logic                  better;
    logic                  take;
    logic                  complete;
    logic                  have_max_d;
    logic [7:0]            class_id_d;
    logic [DATA_WIDTH-1:0] class_value_d;
    logic [7:0]            node_count_d;
    logic                  error_d;

    always_comb begin
        accept   = (state_q == COLLECT) && node_valid && output_layer;
        in_range = node_index < 8'(NUM_CLASSES);
        // Equal values resolve to the lower index so arrival order never matters.
        better   = !have_max_q
                 || ($signed(node_value) > $signed(class_value_q))
                 || ((node_value == class_value_q) && (node_index < class_id_q));
        take     = accept && in_range && better;
        complete = (state_q == COLLECT) && ready && !ready_q;

        have_max_d    = have_max_q | take;
        class_id_d    = take ? node_index : class_id_q;
        class_value_d = take ? node_value : class_value_q;
        node_count_d  = node_count_q;
        if (accept && in_range && (node_count_q != 8'hFF)) begin
            node_count_d = node_count_q + 8'd1;
        end
        // A node landing on the completion edge counts toward have_max_d.
        error_d = error_q | (accept && !in_range) | (complete && !have_max_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            ready_q        <= 1'b1;
            have_max_q     <= 1'b0;
            class_id_q     <= 8'hFF;
            class_value_q  <= '0;
            node_count_q   <= 8'd0;
            result_valid_q <= 1'b0;
            done_pulse_q   <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            ready_q      <= ready;
            done_pulse_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (run_inference) begin
                        state_q        <= COLLECT;
                        have_max_q     <= 1'b0;
                        class_id_q     <= 8'hFF;
                        class_value_q  <= '0;
                        node_count_q   <= 8'd0;
                        result_valid_q <= 1'b0;
                        error_q        <= 1'b0;
                    end
                end
                COLLECT: begin
                    have_max_q    <= have_max_d;
                    class_id_q    <= class_id_d;
                    class_value_q <= class_value_d;
                    node_count_q  <= node_count_d;
                    error_q       <= error_d;
                    if (complete) begin
                        state_q        <= DONE;
                        result_valid_q <= 1'b1;
                        done_pulse_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign class_id     = class_id_q;
    assign class_value  = class_value_q;
    assign node_count   = node_count_q;
    assign result_valid = result_valid_q;
    assign done_pulse   = done_pulse_q;
    assign error        = error_q;

endmodule

// File: tb/tb_output_argmax.sv
// Bench for output_argmax: queue-based argmax model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_output_argmax;
    localparam int DW = 8;
    localparam int NC = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run_inference = 1'b0;
    logic          ready = 1'b1;
    logic          output_layer = 1'b0;
    logic          node_valid = 1'b0;
    logic [DW-1:0] node_value = '0;
    logic [7:0]    node_index = '0;
    logic [7:0]    class_id;
    logic [DW-1:0] class_value;
    logic [7:0]    node_count;
    logic          result_valid;
    logic          done_pulse;
    logic          error;

    output_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
        .clk(clk), .reset(reset), .run_inference(run_inference), .ready(ready),
        .output_layer(output_layer), .node_valid(node_valid), .node_value(node_value),
        .node_index(node_index), .class_id(class_id), .class_value(class_value),
        .node_count(node_count), .result_valid(result_valid), .done_pulse(done_pulse),
        .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the set of accepted nodes for this inference, and whether results are published.
    int q_val[$];
    int q_idx[$];
    bit m_collect = 0;
    bit m_rv = 0;
    bit m_dp = 0;
    bit m_err = 0;
    bit m_ready_prev = 1;
    int m_count = 0;

    function automatic int model_id();
        int best_v, best_i;
        if (q_val.size() == 0) return 255;
        best_v = q_val[0]; best_i = q_idx[0];
        foreach (q_val[k])
            if (q_val[k] > best_v || (q_val[k] == best_v && q_idx[k] < best_i)) begin
                best_v = q_val[k]; best_i = q_idx[k];
            end
        return best_i;
    endfunction

    function automatic int model_val();
        int best_v;
        if (q_val.size() == 0) return 0;
        best_v = q_val[0];
        foreach (q_val[k]) if (q_val[k] > best_v) best_v = q_val[k];
        return best_v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q_val.delete(); q_idx.delete();
            m_collect = 0; m_rv = 0; m_dp = 0; m_err = 0; m_count = 0; m_ready_prev = 1;
        end else begin
            m_dp = 0;
            if (!m_collect) begin
                if (run_inference) begin
                    m_collect = 1; m_rv = 0; m_err = 0; m_count = 0;
                    q_val.delete(); q_idx.delete();
                end
            end else begin
                if (node_valid && output_layer) begin
                    if (node_index >= NC) m_err = 1;
                    else begin
                        q_val.push_back(int'($signed(node_value)));
                        q_idx.push_back(int'(node_index));
                        if (m_count < 255) m_count++;
                    end
                end
                if (ready && !m_ready_prev) begin
                    m_collect = 0; m_rv = 1; m_dp = 1;
                    if (q_val.size() == 0) m_err = 1;
                end
            end
            m_ready_prev = ready;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("class_id", int'(class_id), model_id());
            chk("class_value", int'($signed(class_value)), model_val());
            chk("node_count", int'(node_count), m_count);
            chk("result_valid", int'(result_valid), int'(m_rv));
            chk("done_pulse", int'(done_pulse), int'(m_dp));
            chk("error", int'(error), int'(m_err));
            if (done_pulse) pulse_cnt++;
        end
    end

    task automatic start();
        run_inference = 1; ready = 0;
        @(negedge clk);
        run_inference = 0;
    endtask

    task automatic node(input int v, input int idx, input bit ol = 1, input bit rdy = 0);
        node_valid = 1; output_layer = ol; node_value = DW'(v); node_index = 8'(idx); ready = rdy;
        @(negedge clk);
        node_valid = 0; output_layer = 0;
    endtask

    task automatic finish();
        pulse_cnt = 0;
        ready = 1;
        @(negedge clk);
    endtask

    task automatic expect_result(input string name, input int id, input int val, input int cnt, input int err);
        chk({name, "_id"}, int'(class_id), id);
        chk({name, "_val"}, int'($signed(class_value)), val);
        chk({name, "_cnt"}, int'(node_count), cnt);
        chk({name, "_rv"}, int'(result_valid), 1);
        chk({name, "_err"}, int'(error), err);
        repeat (2) @(negedge clk);
        chk({name, "_pulses"}, pulse_cnt, 1);
    endtask

    int basic_vals[10] = '{3, -5, 17, 2, 17, 0, -128, 127, 9, 1};

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 0;
        @(negedge clk);
        chk("reset_id", int'(class_id), 255);
        chk("reset_cnt", int'(node_count), 0);
        chk("reset_rv", int'(result_valid), 0);
        repeat (2) @(negedge clk);
        chk("reset_no_pulse", int'(done_pulse), 0);

        // Basic max
        start();
        for (int i = 0; i < 10; i++) node(basic_vals[i], i);
        finish();
        chk("basic_pulse_now", int'(done_pulse), 1);
        expect_result("basic", 7, 127, 10, 0);

        // Equal values, lowest index wins regardless of order
        start();
        node(-1, 4); node(-1, 2); node(-1, 5); node(-1, 9);
        finish();
        expect_result("tie", 2, -1, 4, 0);

        start();
        for (int i = 9; i >= 0; i--) node(-128, i);
        finish();
        expect_result("allmin", 0, -128, 10, 0);

        // Non-output-layer nodes are ignored
        start();
        node(100, 3, 0);
        for (int i = 0; i < 10; i++) node(i % 6, i);
        finish();
        expect_result("qual", 5, 5, 10, 0);

        // Empty inference
        start();
        @(negedge clk);
        finish();
        expect_result("empty", 255, 0, 0, 1);

        // Out-of-range index
        start();
        node(100, 12); node(4, 1);
        finish();
        expect_result("range", 1, 4, 1, 1);

        // Last node on the completion edge, plus start ignored mid-collection
        start();
        for (int i = 0; i < 5; i++) node(i, i);
        run_inference = 1;
        node(7, 5);
        run_inference = 0;
        chk("busy_start_cnt", int'(node_count), 6);
        for (int i = 6; i < 9; i++) node(i, i);
        pulse_cnt = 0;
        node(50, 9, 1, 1);
        expect_result("edge", 9, 50, 10, 0);

        // Start and ready edge together in DONE: start wins
        ready = 0;
        @(negedge clk);
        ready = 1; run_inference = 1;
        @(negedge clk);
        run_inference = 0;
        chk("startwins_rv", int'(result_valid), 0);
        // Ready held high: no completion without a rising edge
        node(20, 3, 1, 1);
        repeat (3) @(negedge clk);
        chk("hold_high_rv", int'(result_valid), 0);
        ready = 0;
        @(negedge clk);
        finish();
        expect_result("late", 3, 20, 1, 0);

        // Reset mid-collection
        start();
        for (int i = 0; i < 4; i++) node(10 + i, i);
        pulse_cnt = 0;
        #2 reset = 1;
        #1;
        chk("arst_id", int'(class_id), 255);
        chk("arst_val", int'(class_value), 0);
        chk("arst_cnt", int'(node_count), 0);
        chk("arst_rv", int'(result_valid), 0);
        chk("arst_err", int'(error), 0);
        @(negedge clk);
        #2 reset = 0;
        ready = 1;
        repeat (2) @(negedge clk);
        chk("arst_no_pulse", pulse_cnt, 0);
        start();
        node(-3, 6); node(8, 2);
        finish();
        expect_result("after_rst", 2, 8, 2, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
